src_poly_osc: RTL and testbench

- N-voice, time-multiplexed phase-accumulator oscillator. Each voice selects sine, square, saw or triangle, and has its own gate and per-voice envelope.
- Voices are processed serially, one per mclk, after each rising pblrc edge. They are summed, scaled by master volume and saturated to one signed 16-bit sample.
- Sits in the synth source chain ahead of the overdrive stage and the I2S serializer.

---
 rtl/src_poly_osc_if.sv | 38 +++
 rtl/src_poly_osc.sv | 203 ++++++++++++++++++++
 tb/tb_src_poly_osc.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/src_poly_osc_if.sv
// Purpose : bundles the sample-rate strobe, the per-voice controls and the mixed sample output of src_poly_osc.
// Latency : n/a (signal bundle only).
// Backpres: none; the oscillator has no output stall, the consumer takes p_sample_buffer on sample_valid.
//
// Signals:
//   pblrc           sample-rate clock, synchronous to mclk
//   voice_gate      per-voice note gate
//   voice_freq      per-voice phase increment per sample
//   voice_wave      per-voice waveform: 0 sine, 1 square, 2 saw, 3 triangle
//   volume          master volume (unsigned)
//   p_sample_buffer mixed, saturated signed 16-bit sample
//   sample_valid    one-mclk pulse when p_sample_buffer updates
//   busy            high while a sample is being computed
// master = control/consumer side, slave = oscillator side.
interface src_poly_osc_if #(
  parameter int NUM_VOICES  = 8,
  parameter int PHASE_BITS  = 24,
  parameter int VOLUME_BITS = 8
);
  logic                                  pblrc;
  logic [NUM_VOICES-1:0]                 voice_gate;
  logic [NUM_VOICES-1:0][PHASE_BITS-1:0] voice_freq;
  logic [NUM_VOICES-1:0][1:0]            voice_wave;
  logic [VOLUME_BITS-1:0]                volume;
  logic signed [15:0]                    p_sample_buffer;
  logic                                  sample_valid;
  logic                                  busy;

  modport master (
    output pblrc, voice_gate, voice_freq, voice_wave, volume,
    input  p_sample_buffer, sample_valid, busy
  );

  modport slave (
    input  pblrc, voice_gate, voice_freq, voice_wave, volume,
    output p_sample_buffer, sample_valid, busy
  );
endinterface

// File: rtl/src_poly_osc.sv
// Purpose : N-voice time-multiplexed phase-accumulator oscillator (sine/square/saw/triangle) with per-voice envelope,
//           summed, scaled by master volume and saturated to one signed 16-bit sample per pblrc rise.
// Latency : sample_valid NUM_VOICES+3 mclk edges after the pblrc rise is first sampled; no backpressure, rises while busy are dropped.
//
// Ports   : mclk (master clock), rst (async, active-low), bus (src_poly_osc_if.slave: pblrc, voice_* controls, volume,
//           p_sample_buffer, sample_valid, busy).
// Build   : define SRC_POLY_OSC_ENVELOPE_EN for attack/decay ramps; otherwise the envelope snaps to full/zero with the gate.
module src_poly_osc #(
  parameter int NUM_VOICES  = 8,
  parameter int LUT_SIZE    = 256,
  parameter int PHASE_BITS  = 24,
  parameter int VOLUME_BITS = 8,
  parameter int ENV_BITS    = 8,
  parameter int ATTACK_STEP = 16,
  parameter int DECAY_STEP  = 4
) (
  input logic           mclk,
  input logic           rst,
  src_poly_osc_if.slave bus
);

  localparam int LB = $clog2(LUT_SIZE);
  localparam int VB = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  localparam int AW = 16 + $clog2(NUM_VOICES) + 1;
  localparam int PW = AW + VOLUME_BITS + 1;
  localparam int MW = 16 + ENV_BITS + 1;

  localparam logic [ENV_BITS-1:0]  ENV_MAX = '1;
  localparam logic signed [PW-1:0] SAT_HI  = PW'(32767);
  localparam logic signed [PW-1:0] SAT_LO  = PW'(-32768);

  if (NUM_VOICES < 1 || NUM_VOICES > 64 || PHASE_BITS < 16 || LUT_SIZE < 4 ||
      (LUT_SIZE & (LUT_SIZE - 1)) != 0 || ATTACK_STEP < 0 || DECAY_STEP < 0) begin : g_bad_params
    $error("src_poly_osc: illegal parameter set");
  end

  // Quarter-wave folded Taylor series in Q28 fixed point; pi/2 lands exactly on 32767.
  function automatic logic signed [15:0] sine_entry(input int idx);
    longint x, x2, term, sum, k;
    longint half, quarter;
    half    = LUT_SIZE / 2;
    quarter = LUT_SIZE / 4;
    k = longint'(idx) % half;
    if (k > quarter) k = half - k;
    x    = (k * 64'sd1686629713) / LUT_SIZE;   // 2*pi in Q28
    x2   = (x * x) >>> 28;
    term = x;
    sum  = x;
    for (int n = 1; n <= 6; n++) begin
      term = -((term * x2) >>> 28) / longint'((2 * n) * (2 * n + 1));
      sum  = sum + term;
    end
    sum = (sum * 32767 + (longint'(1) <<< 27)) >>> 28;
    if (sum > 32767) sum = 32767;
    if (sum < 0)     sum = 0;
    if (longint'(idx) >= half) sum = -sum;
    return 16'(sum);
  endfunction

  logic signed [15:0] sine_lut [LUT_SIZE];
  for (genvar i = 0; i < LUT_SIZE; i++) begin : g_lut
    assign sine_lut[i] = sine_entry(i);
  end

  typedef enum logic [1:0] {IDLE, RUN, SCALE, OUT} state_t;

  state_t                 state_q, state_nxt;
  logic [VB-1:0]          v_q, v_nxt;
  logic signed [AW-1:0]   acc_q, acc_nxt;
  logic signed [PW-1:0]   prod_q, prod_nxt;
  logic [PHASE_BITS-1:0]  phase [NUM_VOICES];
  logic [ENV_BITS-1:0]    env   [NUM_VOICES];
  logic                   pblrc_s, pblrc_d;
  logic                   tick;

  // pblrc is registered once before edge detection, so the FSM sees the rise one edge after it is first sampled.
  assign tick     = pblrc_s & ~pblrc_d;
  assign bus.busy = (state_q != IDLE);

  // ---- current-voice datapath ----
  logic [PHASE_BITS-1:0] cur_phase;
  logic [ENV_BITS-1:0]   env_cur, env_nxt;
  logic                  cur_gate;
  logic [1:0]            cur_wave;
  logic [16:0]           top17;
  logic [15:0]           tri_fold;
  logic signed [15:0]    wave;
  logic signed [MW-1:0]  mult;
  logic signed [AW-1:0]  contrib;
  logic signed [PW-1:0]  acc_ext, vol_ext, prod_full;

  assign cur_phase = phase[v_q];
  assign env_cur   = env[v_q];
  assign cur_gate  = bus.voice_gate[v_q];
  assign cur_wave  = bus.voice_wave[v_q];

  if (PHASE_BITS > 16) begin : g_t17_wide
    assign top17 = cur_phase[PHASE_BITS-1 -: 17];
  end else begin : g_t17_narrow
    assign top17 = {cur_phase, 1'b0};
  end

  // Triangle: the top 17 phase bits fold into a 16-bit up/down ramp; flipping the MSB re-centres it on zero.
  assign tri_fold = top17[16] ? ~top17[15:0] : top17[15:0];

  always_comb begin
    wave = '0;
    unique case (cur_wave)
      2'd0: wave = sine_lut[cur_phase[PHASE_BITS-1 -: LB]];
      2'd1: wave = cur_phase[PHASE_BITS-1] ? -16'sd32767 : 16'sd32767;
      2'd2: wave = cur_phase[PHASE_BITS-1 -: 16] ^ 16'h8000;
      default: begin
        wave = tri_fold ^ 16'h8000;
        if (wave == -16'sd32768) wave = -16'sd32767;
      end
    endcase
  end

  // Envelope is unsigned; the zero-extended operand keeps the multiply signed and the shift floors toward -inf.
  assign mult    = wave * $signed({1'b0, env_cur});
  assign contrib = AW'(mult >>> ENV_BITS);

  assign acc_ext   = PW'(acc_q);
  assign vol_ext   = PW'($signed({1'b0, bus.volume}));
  assign prod_full = acc_ext * vol_ext;

`ifdef SRC_POLY_OSC_ENVELOPE_EN
  localparam logic [ENV_BITS:0]   ATK = (ENV_BITS+1)'(ATTACK_STEP);
  localparam logic [ENV_BITS-1:0] DEC = ENV_BITS'(DECAY_STEP);
  logic [ENV_BITS:0] env_up;
  assign env_up = {1'b0, env_cur} + ATK;
  always_comb begin
    env_nxt = env_cur;
    if (cur_gate) env_nxt = (env_up > {1'b0, ENV_MAX}) ? ENV_MAX : env_up[ENV_BITS-1:0];
    else          env_nxt = (env_cur < DEC) ? '0 : env_cur - DEC;
  end
`else
  assign env_nxt = cur_gate ? ENV_MAX : '0;
`endif

  // ---- FSM ----
  always_comb begin
    state_nxt = state_q;
    v_nxt     = v_q;
    acc_nxt   = acc_q;
    prod_nxt  = prod_q;
    unique case (state_q)
      IDLE: begin
        if (tick) begin
          state_nxt = RUN;
          v_nxt     = '0;
          acc_nxt   = '0;
        end
      end
      RUN: begin
        acc_nxt = acc_q + contrib;
        if (v_q == VB'(NUM_VOICES - 1)) state_nxt = SCALE;
        else                            v_nxt     = v_q + 1'b1;
      end
      SCALE: begin
        prod_nxt  = prod_full >>> VOLUME_BITS;
        state_nxt = OUT;
      end
      default: state_nxt = IDLE;   // OUT
    endcase
  end

  always_ff @(posedge mclk or negedge rst) begin
    if (!rst) begin
      state_q             <= IDLE;
      v_q                 <= '0;
      acc_q               <= '0;
      prod_q              <= '0;
      pblrc_s             <= 1'b0;
      pblrc_d             <= 1'b0;
      bus.p_sample_buffer <= '0;
      bus.sample_valid    <= 1'b0;
      for (int i = 0; i < NUM_VOICES; i++) begin
        phase[i] <= '0;
        env[i]   <= '0;
      end
    end else begin
      state_q          <= state_nxt;
      v_q              <= v_nxt;
      acc_q            <= acc_nxt;
      prod_q           <= prod_nxt;
      pblrc_s          <= bus.pblrc;
      pblrc_d          <= pblrc_s;
      bus.sample_valid <= (state_q == OUT);
      if (state_q == RUN) begin
        // Contribution above used the pre-update phase and envelope.
        phase[v_q] <= cur_phase + bus.voice_freq[v_q];
        env[v_q]   <= env_nxt;
      end
      if (state_q == OUT) begin
        if (prod_q > SAT_HI)      bus.p_sample_buffer <= 16'sd32767;
        else if (prod_q < SAT_LO) bus.p_sample_buffer <= -16'sd32768;
        else                      bus.p_sample_buffer <= prod_q[15:0];
      end
    end
  end

endmodule

// File: tb/tb_src_poly_osc.sv
// Purpose : directed self-checking bench for src_poly_osc with 4 voices and default widths.
// Latency : expects sample_valid NUM_VOICES+3 edges after the pblrc rise is first sampled.
// Backpres: none; the bench simply waits (bounded) for each sample_valid pulse.
module tb_src_poly_osc;

  localparam int NV = 4;
  localparam logic [23:0] HALF = 24'h800000;
  localparam logic [23:0] QTR  = 24'h400000;

`ifdef SRC_POLY_OSC_ENVELOPE_EN
  localparam int WARM    = 16;
  localparam int DECAY_N = 65;
  localparam int EXP_S2  = 2039;
`else
  localparam int WARM    = 1;
  localparam int DECAY_N = 2;
  localparam int EXP_S2  = 32511;
`endif

  logic mclk;
  logic rst;

  src_poly_osc_if #(.NUM_VOICES(NV), .PHASE_BITS(24), .VOLUME_BITS(8)) sif ();

  src_poly_osc #(.NUM_VOICES(NV)) dut (
    .mclk (mclk),
    .rst  (rst),
    .bus  (sif.slave)
  );

  initial mclk = 1'b0;
  always #5 mclk = ~mclk;

  int n_chk  = 0;
  int n_pass = 0;
  int lat_g;
  int vld_after_g;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic set_voice(input int i, input logic g, input logic [23:0] f, input logic [1:0] w);
    sif.voice_gate[i] = g;
    sif.voice_freq[i] = f;
    sif.voice_wave[i] = w;
  endtask

  // One pblrc rise; returns the sample and records edges counted after the first sampling edge.
  task automatic take_sample(output int s);
    int  n;
    bit  seen;
    n    = 0;
    seen = 0;
    @(negedge mclk);
    sif.pblrc = 1'b1;
    while (!seen && n < 40) begin
      @(posedge mclk);
      #1;
      n++;
      if (sif.sample_valid) seen = 1;
    end
    if (!seen) chk("valid_timeout", 0, 1);
    s     = int'(sif.p_sample_buffer);
    lat_g = n - 1;
    @(posedge mclk);
    #1;
    vld_after_g = int'(sif.sample_valid);
    @(negedge mclk);
    sif.pblrc = 1'b0;
    repeat (3) @(negedge mclk);
  endtask

  int s, prev, mono, pulses;
  int alt_exp [3] = '{32511, -32513, 32511};
  int wave_exp [3][4] = '{'{0, -32513, 0, 32511},
                          '{0, 16256, -32513, -16257},
                          '{32511, -1, -32513, 0}};
  logic [1:0] wave_sel [3] = '{2'd0, 2'd2, 2'd3};

  initial begin
    rst        = 1'b0;
    sif.pblrc  = 1'b0;
    sif.volume = 8'd255;
    for (int i = 0; i < NV; i++) set_voice(i, 1'b0, 24'd0, 2'd0);
    repeat (2) @(posedge mclk);
    #1;
    chk("reset_buf",  int'(sif.p_sample_buffer), 0);
    chk("reset_vld",  int'(sif.sample_valid), 0);
    chk("reset_busy", int'(sif.busy), 0);
    @(negedge mclk);
    rst = 1'b1;
    repeat (2) @(negedge mclk);

    // Single square voice, freq 0: envelope ramps from zero.
    set_voice(0, 1'b1, 24'd0, 2'd1);
    take_sample(s);
    chk("sq_s1", s, 0);
    chk("latency", lat_g, NV + 3);
    chk("single_pulse", vld_after_g, 0);
    take_sample(s);
    chk("sq_s2", s, EXP_S2);
    prev = s;
    mono = 1;
    for (int k = 3; k <= WARM; k++) begin
      take_sample(s);
      if (s < prev) mono = 0;
      prev = s;
    end
    chk("ramp_mono", mono, 1);
    take_sample(s);
    chk("sq_full", s, 32511);
    repeat (20) @(negedge mclk);
    chk("hold_buf", int'(sif.p_sample_buffer), 32511);
    chk("idle_vld", int'(sif.sample_valid), 0);

    sif.volume = 8'd0;
    take_sample(s);
    chk("vol0", s, 0);
    sif.volume = 8'd128;
    take_sample(s);
    chk("vol128", s, 16319);
    sif.volume = 8'd255;

    // Half-cycle increment: square alternates each sample.
    sif.voice_freq[0] = HALF;
    for (int k = 0; k < 3; k++) begin
      take_sample(s);
      chk($sformatf("alt%0d", k), s, alt_exp[k]);
    end

    // Quarter-cycle increment starting from half phase: sine, saw, triangle.
    sif.voice_freq[0] = QTR;
    for (int w = 0; w < 3; w++) begin
      sif.voice_wave[0] = wave_sel[w];
      for (int k = 0; k < 4; k++) begin
        take_sample(s);
        chk($sformatf("wave%0d_%0d", wave_sel[w], k), s, wave_exp[w][k]);
      end
    end

    set_voice(0, 1'b1, 24'd0, 2'd1);
    take_sample(s);
    chk("pre_rst", s, -32513);

    // Reset while the FSM is on voice 3.
    @(negedge mclk);
    sif.pblrc = 1'b1;
    repeat (5) @(posedge mclk);
    #1;
    chk("busy_run", int'(sif.busy), 1);
    rst = 1'b0;
    #1;
    chk("rst_buf",  int'(sif.p_sample_buffer), 0);
    chk("rst_vld",  int'(sif.sample_valid), 0);
    chk("rst_busy", int'(sif.busy), 0);
    @(negedge mclk);
    sif.pblrc = 1'b0;
    repeat (2) @(negedge mclk);
    rst = 1'b1;
    repeat (2) @(negedge mclk);
    for (int i = 0; i < NV; i++) set_voice(i, 1'b0, 24'd0, 2'd1);
    take_sample(s);
    chk("post_rst", s, 0);

    // All four voices square at full envelope: saturation both ways.
    for (int i = 0; i < NV; i++) set_voice(i, 1'b1, 24'd0, 2'd1);
    repeat (WARM) take_sample(s);
    take_sample(s);
    chk("sat_pos", s, 32767);
    for (int i = 0; i < NV; i++) sif.voice_freq[i] = HALF;
    take_sample(s);
    chk("sat_pos2", s, 32767);
    take_sample(s);
    chk("sat_neg", s, -32768);

    // Second rise while busy must be dropped.
    @(negedge mclk);
    sif.pblrc = 1'b1;
    repeat (2) @(negedge mclk);
    sif.pblrc = 1'b0;
    repeat (2) @(negedge mclk);
    sif.pblrc = 1'b1;
    pulses = 0;
    repeat (30) begin
      @(posedge mclk);
      #1;
      if (sif.sample_valid) begin
        pulses++;
        s = int'(sif.p_sample_buffer);
      end
    end
    chk("ign_pulses", pulses, 1);
    chk("ign_val", s, 32767);
    @(negedge mclk);
    sif.pblrc = 1'b0;
    repeat (3) @(negedge mclk);
    take_sample(s);
    chk("ign_adv", s, -32768);

    // Gates off: envelope falls to zero and stays there.
    for (int i = 0; i < NV; i++) set_voice(i, 1'b0, 24'd0, 2'd1);
    take_sample(s);
    chk("decay_first", s, 32767);
    prev = s;
    mono = 1;
    for (int k = 2; k <= DECAY_N; k++) begin
      take_sample(s);
      if (s > prev) mono = 0;
      prev = s;
    end
    chk("decay_mono", mono, 1);
    chk("decay_zero", s, 0);
    take_sample(s);
    chk("decay_hold", s, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
